// File: rtl/sigmoid_coef_bank.sv
// Writable coefficient bank for the piecewise Maclaurin sigmoid unit.
// Two-stage registered read pipeline (request, output) with valid/ready backpressure.
module sigmoid_coef_bank #(
  parameter int DATA_W   = 16,
  parameter int SEG_BITS = 3,
  parameter int NTERM    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_valid,
  output logic                      rd_ready,
  input  logic [SEG_BITS-1:0]       rd_seg,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NTERM*DATA_W-1:0]   coef_out,
  output logic [SEG_BITS-1:0]       out_seg,
  input  logic                      wr_en,
  input  logic [SEG_BITS-1:0]       wr_seg,
  input  logic [2:0]                wr_term,
  input  logic [DATA_W-1:0]         wr_data,
  output logic                      wr_err
);

  localparam int          NSEG = 1 << SEG_BITS;
  localparam int unsigned NT   = NTERM;

  logic [DATA_W-1:0]       r_mem [NSEG][NTERM];
  logic                    r_wr_err;
  logic                    r_s1_valid;
  logic [SEG_BITS-1:0]     r_s1_seg;
  logic                    r_out_valid;
  logic [SEG_BITS-1:0]     r_out_seg;
  logic [NTERM*DATA_W-1:0] r_coef;
  logic [NTERM*DATA_W-1:0] w_rd_word;
  logic                    w_stall;
  logic                    w_term_ok;

  // Term-1 reset values; narrower table is zero-extended for wide DATA_W.
  function automatic logic [DATA_W-1:0] f_term1_default(input int unsigned seg);
    logic [15:0] v;
    case (seg)
      0:       v = 16'h0200;
      1:       v = 16'h0345;
      2:       v = 16'h03B2;
      3:       v = 16'h03E1;
      4, 5:    v = 16'h03F9;
      default: v = 16'h0400;
    endcase
    return DATA_W'(v);
  endfunction

  assign w_stall   = r_out_valid & ~out_ready;
  assign w_term_ok = ({29'b0, wr_term} < NT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSEG; s++) begin
        for (int unsigned t = 0; t < NT; t++) begin
          r_mem[s][t] <= (t == 1) ? f_term1_default(s) : '0;
        end
      end
      r_wr_err <= 1'b0;
    end else if (wr_en) begin
      if (w_term_ok) begin
        for (int unsigned t = 0; t < NT; t++) begin
          if (wr_term == 3'(t)) r_mem[wr_seg][t] <= wr_data;
        end
      end else begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // Pre-edge array contents, so a same-edge write is not seen by this transfer.
  always_comb begin
    w_rd_word = '0;
    for (int unsigned k = 0; k < NT; k++) begin
      w_rd_word[k*DATA_W +: DATA_W] = r_mem[r_s1_seg][k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_seg    <= '0;
      r_out_valid <= 1'b0;
      r_out_seg   <= '0;
      r_coef      <= '0;
    end else if (!w_stall) begin
      r_s1_valid  <= rd_valid;
      r_s1_seg    <= rd_seg;
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_seg <= r_s1_seg;
        r_coef    <= w_rd_word;
      end
    end
  end

  assign rd_ready  = ~w_stall;
  assign out_valid = r_out_valid;
  assign out_seg   = r_out_seg;
  assign coef_out  = r_coef;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_sigmoid_coef_bank.sv
// Bench for sigmoid_coef_bank: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_sigmoid_coef_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_valid = 1'b0;
  logic        rd_ready;
  logic [2:0]  rd_seg = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] coef_out;
  logic [2:0]  out_seg;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_seg = '0;
  logic [2:0]  wr_term = '0;
  logic [15:0] wr_data = '0;
  logic        wr_err;

  int n_chk  = 0;
  int n_pass = 0;

  sigmoid_coef_bank #(.DATA_W(16), .SEG_BITS(3), .NTERM(4)) dut (
    .clk(clk), .rst(rst), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_seg(rd_seg),
    .out_valid(out_valid), .out_ready(out_ready), .coef_out(coef_out), .out_seg(out_seg),
    .wr_en(wr_en), .wr_seg(wr_seg), .wr_term(wr_term), .wr_data(wr_data), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: array + ordered list of accepted requests ----------
  typedef struct { int seg; int acc; } req_t;
  logic [15:0] mdl [8][4];
  req_t        pend [$];
  int          edge_n;
  logic        m_ov;
  logic [2:0]  m_seg;
  logic [63:0] m_coef;
  logic        m_err;

  function automatic logic [15:0] dflt(input int s, input int t);
    logic [15:0] tbl [8] = '{16'h0200, 16'h0345, 16'h03B2, 16'h03E1,
                             16'h03F9, 16'h03F9, 16'h0400, 16'h0400};
    return (t == 1) ? tbl[s] : 16'h0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 8; s++) for (int t = 0; t < 4; t++) mdl[s][t] = dflt(s, t);
      pend.delete();
      edge_n = 0; m_ov = 0; m_seg = '0; m_coef = '0; m_err = 0;
    end else begin
      if (!(m_ov && !out_ready)) begin
        // the oldest request accepted on an earlier edge reaches the output now
        m_ov = 0;
        if (pend.size() > 0 && pend[0].acc < edge_n) begin
          req_t r;
          r = pend.pop_front();
          m_seg = 3'(r.seg);
          for (int k = 0; k < 4; k++) m_coef[k*16 +: 16] = mdl[r.seg][k];
          m_ov = 1;
        end
        if (rd_valid) pend.push_back('{int'(rd_seg), edge_n});
      end
      if (wr_en) begin
        if (wr_term < 3'd4) mdl[wr_seg][wr_term[1:0]] = wr_data;
        else m_err = 1;
      end
      edge_n++;
    end
  end

  // ---------------- per-cycle compare against the model ----------------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_ready",  64'(rd_ready),  64'(!(m_ov && !out_ready)));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_seg",   64'(out_seg),   64'(m_seg));
      chk("coef_out",  coef_out,       m_coef);
      chk("wr_err",    64'(wr_err),    64'(m_err));
    end
  end

  // consumed results, for order / loss / duplicate checks
  logic [2:0]  cons_seg  [$];
  logic [63:0] cons_coef [$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      cons_seg.push_back(out_seg);
      cons_coef.push_back(coef_out);
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) --------------------
  task automatic issue(input int s);
    logic acc;
    rd_valid = 1'b1;
    rd_seg   = 3'(s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = rd_ready;
      @(posedge clk);
      #2;
      if (acc) return;
    end
    chk("issue_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic write1(input int s, input int t, input logic [15:0] d);
    wr_en = 1'b1; wr_seg = 3'(s); wr_term = 3'(t); wr_data = d;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic read_one(input int s, output logic [63:0] c);
    issue(s);
    rd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("read_one_valid", 64'(out_valid), 64'd1);
    c = coef_out;
    @(posedge clk); #2;
  endtask

  logic [63:0] c;
  logic [15:0] exp_t1 [8] = '{16'h0200, 16'h0345, 16'h03B2, 16'h03E1,
                              16'h03F9, 16'h03F9, 16'h0400, 16'h0400};

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;

    // reset state
    chk("rst_rd_ready",  64'(rd_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_coef",      coef_out,       64'd0);
    chk("rst_wr_err",    64'(wr_err),    64'd0);

    // defaults, back-to-back
    cons_seg.delete(); cons_coef.delete();
    for (int s = 0; s < 8; s++) issue(s);
    rd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("dflt_count", 64'(cons_seg.size()), 64'd8);
    for (int s = 0; s < 8 && s < cons_seg.size(); s++) begin
      chk("dflt_seg",  64'(cons_seg[s]), 64'(s));
      chk("dflt_coef", cons_coef[s], {32'h0, exp_t1[s], 16'h0});
    end

    // write then read
    write1(2, 3, 16'hFC18);
    read_one(2, c);
    chk("wr_rd_seg2", c, 64'hFC18_0000_03B2_0000);

    // collision: write on the S1->S2 transfer edge of a seg5 read
    issue(5);
    rd_valid = 1'b0;
    wr_en = 1'b1; wr_seg = 3'd5; wr_term = 3'd1; wr_data = 16'h0111;
    @(posedge clk); #2;
    wr_en = 1'b0;
    @(negedge clk);
    chk("coll_valid", 64'(out_valid), 64'd1);
    chk("coll_old",   coef_out, 64'h0000_0000_03F9_0000);
    @(posedge clk); #2;
    read_one(5, c);
    chk("coll_new", c, 64'h0000_0000_0111_0000);

    // backpressure
    cons_seg.delete(); cons_coef.delete();
    out_ready = 1'b0;
    fork
      begin
        issue(1); issue(6); issue(3);
        rd_valid = 1'b0;
      end
      begin
        int k;
        for (k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        if (k == 20) chk("bp_valid_timeout", 64'd0, 64'd1);
        for (int j = 0; j < 4; j++) begin
          if (j > 0) @(negedge clk);
          chk("bp_rd_ready", 64'(rd_ready), 64'd0);
          chk("bp_seg",      64'(out_seg),  64'd1);
          chk("bp_coef",     coef_out,      64'h0000_0000_0345_0000);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #2;
    chk("bp_count", 64'(cons_seg.size()), 64'd3);
    if (cons_seg.size() == 3) begin
      chk("bp_order0", 64'(cons_seg[0]), 64'd1);
      chk("bp_order1", 64'(cons_seg[1]), 64'd6);
      chk("bp_order2", 64'(cons_seg[2]), 64'd3);
      chk("bp_coef6",  cons_coef[1], 64'h0000_0000_0400_0000);
    end

    // illegal write
    write1(3, 7, 16'hDEAD);
    chk("ill_err", 64'(wr_err), 64'd1);
    read_one(3, c);
    chk("ill_unchanged", c, 64'h0000_0000_03E1_0000);
    repeat (3) @(posedge clk);
    #2;
    chk("ill_sticky", 64'(wr_err), 64'd1);

    // reset mid-operation
    write1(0, 1, 16'h0123);
    issue(0); issue(1);
    rd_valid = 1'b0;
    chk("mid_inflight", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_wr_err",    64'(wr_err),    64'd0);
    chk("mid_rd_ready",  64'(rd_ready),  64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    read_one(0, c);
    chk("mid_seg0_dflt", c, 64'h0000_0000_0200_0000);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/sigmoid_coef_bank.md
# sigmoid_coef_bank

Parametrised, writable coefficient bank for the piecewise Maclaurin sigmoid unit. Holds NTERM signed fixed-point coefficients for each of 2^SEG_BITS input segments. Returns all terms of a requested segment through a 2-stage registered pipeline with a valid/ready handshake. A write port allows coefficients to be reloaded at run time, replacing the fixed combinational term-1 lookup.

## Interface
- DATA_W, 16, coefficient width, signed two's complement, 10 fractional bits; legal range 16..32
- SEG_BITS, 3, segment index width; 2^SEG_BITS segments; legal range 3..6
- NTERM, 4, coefficients per segment (term 0..NTERM-1); legal range 2..8
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_valid  in  1  read request present
- rd_ready  out  1  bank can accept a read this cycle
- rd_seg  in  SEG_BITS  segment index of the request
- out_valid  out  1  coef_out holds a completed read
- out_ready  in  1  consumer accepts coef_out
- coef_out  out  NTERM*DATA_W  term k at bits [k*DATA_W +: DATA_W]
- out_seg  out  SEG_BITS  segment index belonging to coef_out
- wr_en  in  1  write strobe
- wr_seg  in  SEG_BITS  segment to write
- wr_term  in  3  term index to write
- wr_data  in  DATA_W  coefficient value
- wr_err  out  1  sticky flag: a write with wr_term >= NTERM was seen

## Operation
- Storage: register array of 2^SEG_BITS × NTERM × DATA_W.
- Reset contents: all terms 0, except term 1:
  - seg0 = 0x0200, seg1 = 0x0345, seg2 = 0x03B2, seg3 = 0x03E1, seg4 = seg5 = 0x03F9.
  - Every segment >= 6 = 0x0400.
  - For DATA_W > 16, these values are zero-extended in the MSBs.
- Write: on a clk edge with wr_en=1 and wr_term < NTERM, entry [wr_seg][wr_term] = wr_data.
  - wr_term >= NTERM: array unchanged and wr_err is set to 1. wr_err clears only on rst.
- Pipeline, stage S1 (request register): s1_valid and s1_seg.
- Pipeline, stage S2 (output register): out_valid, out_seg, coef_out.
- Stall: stall = out_valid & ~out_ready. rd_ready = ~stall.
- When not stalled, each clk edge performs:
  - S1 ← (rd_valid, rd_seg).
  - S2 ← (s1_valid, s1_seg, array[s1_seg]).
- When stalled, S1 and S2 hold. A rd_valid request is not accepted; the requester keeps it until rd_ready=1.
- Array read happens on the S1→S2 transfer edge and uses pre-edge contents.
  - A write on the same edge to the same segment is not visible to that read.
  - It is visible to any later transfer.
- Writes are accepted every cycle regardless of stall.
- coef_out and out_seg change only on a non-stalled edge where s1_valid=1.
  - A bubble (s1_valid=0) clears out_valid but leaves coef_out and out_seg unchanged.

## Timing
- Reset values: rd_ready=1, out_valid=0, coef_out=0, out_seg=0, wr_err=0, s1_valid=0, array as listed above.
- Reset is asynchronous. Asserting rst mid-transaction discards S1/S2 contents and restores the array defaults in the same cycle.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1 (2 edges), provided out_ready stayed high.
- Throughput: one read per cycle while out_ready=1.
- Handshake: a result is consumed on an edge with out_valid & out_ready.
  - Under stall, out_valid, coef_out and out_seg are stable.
  - rd_ready is purely combinational from out_valid and out_ready.
- Simultaneous events:
  - Read and write to the same segment on the same edge: the read returns old data.
  - Two back-to-back requests plus a stall: both are retained in order and none are lost or duplicated.

## Test plan
- Defaults: after rst, read seg 0..7 back-to-back with out_ready=1. Expect term1 = 0x0200, 0x0345, 0x03B2, 0x03E1, 0x03F9, 0x03F9, 0x0400, 0x0400, all other terms 0, each result 2 cycles after its request, one per cycle.
- Write then read: write seg2/term3 = 0xFC18, then read seg2. Expect coef_out term3 = 0xFC18 and term1 still 0x03B2.
- Collision: write seg5/term1 = 0x0111 on the same edge as the S1→S2 transfer of a seg5 read. Expect 0x03F9 from that read; an immediate re-read returns 0x0111.
- Backpressure: issue seg1, seg6, seg3 and hold out_ready=0 for 4 cycles after the first out_valid. Expect rd_ready=0 during the stall, coef_out/out_seg stable at seg1, then outputs in order seg1, seg6, seg3 with no loss or duplicate.
- Illegal write: wr_term=7 with NTERM=4. Expect wr_err=1, array unchanged (readback equals defaults), wr_err held until rst.
- Reset mid-operation: write seg0/term1 = 0x0123 and have a request in flight, then pulse rst. Expect out_valid=0 immediately, wr_err=0, and a later seg0 read returns 0x0200.
